tx_arbiter: RTL and testbench

TX_ARBITER -- requirements
Module: tx_arbiter

---
 rtl/tx_arbiter_pkg.sv | 24 ++
 rtl/tx_framer.sv | 80 ++++++++
 rtl/tx_arbiter.sv | 90 +++++++++
 tb/tb_tx_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arbiter_pkg.sv
// Shared constants for the TX arbiter: state encodings, frame lengths and requester indices.
package tx_arbiter_pkg;

  localparam int unsigned TX_CMD_BITS_DEFAULT = 2;
  localparam int unsigned START_CYCLES        = 1;

  localparam int unsigned REQ_SCHED    = 0;
  localparam int unsigned REQ_PREFETCH = 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_START   = 2'd1;
  localparam logic [1:0] ST_CMD     = 2'd2;
  localparam logic [1:0] ST_PAYLOAD = 2'd3;

  function automatic int unsigned cmd_cycles(input int unsigned cmd_bits,
                                             input int unsigned nshift);
    return cmd_bits / nshift;
  endfunction

  function automatic logic [1:0] owner_mask(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/tx_framer.sv
// Frame serializer: START marker, MSB-first command, then the owner's payload chunks.
module tx_framer
  import tx_arbiter_pkg::*;
#(
  parameter int unsigned NSHIFT         = 2,
  parameter int unsigned PAYLOAD_CYCLES = 8,
  parameter int unsigned TX_CMD_BITS    = TX_CMD_BITS_DEFAULT,
  parameter int unsigned CW             = $clog2(PAYLOAD_CYCLES) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [TX_CMD_BITS-1:0] cmd,
  input  logic [NSHIFT-1:0]      data,
  output logic                   idle,
  output logic                   payload,
  output logic                   last,
  output logic [NSHIFT-1:0]      tx_pins,
  output logic                   tx_active,
  output logic [CW-1:0]          tx_counter
);

  localparam int unsigned CMD_CYCLES = cmd_cycles(TX_CMD_BITS, NSHIFT);
  localparam int unsigned CCW        = $clog2(CMD_CYCLES) + 1;

  logic [1:0]             state;
  logic [TX_CMD_BITS-1:0] cmd_sr;
  logic [CCW-1:0]         ccnt;
  logic [CW-1:0]          pcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cmd_sr <= '0;
      ccnt   <= '0;
      pcnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state  <= ST_START;
          cmd_sr <= cmd;
          ccnt   <= '0;
          pcnt   <= '0;
        end
        ST_START: state <= ST_CMD;
        ST_CMD: begin
          cmd_sr <= cmd_sr << NSHIFT;
          if (ccnt == CCW'(CMD_CYCLES - 1)) state <= ST_PAYLOAD;
          else                              ccnt  <= ccnt + 1'b1;
        end
        ST_PAYLOAD: begin
          if (last) begin
            state <= ST_IDLE;
            pcnt  <= '0;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign idle       = (state == ST_IDLE);
  assign payload    = (state == ST_PAYLOAD);
  assign last       = payload && (pcnt == CW'(PAYLOAD_CYCLES - 1));
  assign tx_active  = !idle;
  assign tx_counter = payload ? pcnt : '0;

  always_comb begin
    tx_pins = '0;
    case (state)
      ST_START:   tx_pins = '1;
      ST_CMD:     tx_pins = cmd_sr[TX_CMD_BITS-1 -: NSHIFT];
      ST_PAYLOAD: tx_pins = data;
      default:    tx_pins = '0;
    endcase
  end

endmodule

// File: rtl/tx_arbiter.sv
// Two-requester TX arbiter: fixed priority grant in idle, reservation and single RX reply tracking.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int unsigned NSHIFT         = 2,
  parameter int unsigned PAYLOAD_CYCLES = 8,
  parameter int unsigned TX_CMD_BITS    = TX_CMD_BITS_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    req_valid,
  input  logic [2*TX_CMD_BITS-1:0]      req_cmd,
  input  logic [1:0]                    req_reply,
  input  logic [2*NSHIFT-1:0]           req_data,
  input  logic                          reserve,
  output logic [1:0]                    started,
  output logic [1:0]                    data_next,
  output logic [1:0]                    done,
  output logic [1:0]                    reply_done,
  input  logic                          rx_done,
  output logic [NSHIFT-1:0]             tx_pins,
  output logic                          tx_active,
  output logic [$clog2(PAYLOAD_CYCLES):0] tx_counter
);

  logic       owner;
  logic       reply_pending;
  logic       reply_owner;
  logic [1:0] eligible;
  logic       grant0, grant1, any_grant, grant_idx;
  logic       framer_idle, framer_payload, framer_last;
  logic [TX_CMD_BITS-1:0] grant_cmd;
  logic [NSHIFT-1:0]      owner_data;

  // Eligibility looks only at the registered reply_pending, never at rx_done.
  assign eligible[REQ_SCHED]    = req_valid[REQ_SCHED] &&
                                  !(req_reply[REQ_SCHED] && reply_pending);
  assign eligible[REQ_PREFETCH] = req_valid[REQ_PREFETCH] && !reserve &&
                                  !(req_reply[REQ_PREFETCH] && reply_pending);

  assign grant0    = framer_idle && !reset && eligible[REQ_SCHED];
  assign grant1    = framer_idle && !reset && eligible[REQ_PREFETCH] && !eligible[REQ_SCHED];
  assign any_grant = grant0 || grant1;
  assign grant_idx = grant1;
  assign started   = {grant1, grant0};

  assign grant_cmd  = grant_idx ? req_cmd[2*TX_CMD_BITS-1 -: TX_CMD_BITS]
                                : req_cmd[TX_CMD_BITS-1:0];
  assign owner_data = owner ? req_data[2*NSHIFT-1 -: NSHIFT] : req_data[NSHIFT-1:0];

  assign data_next  = framer_payload ? owner_mask(owner) : 2'b00;
  assign done       = framer_last ? owner_mask(owner) : 2'b00;
  assign reply_done = (rx_done && reply_pending && !reset) ? owner_mask(reply_owner) : 2'b00;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner         <= 1'b0;
      reply_pending <= 1'b0;
      reply_owner   <= 1'b0;
    end else begin
      if (rx_done && reply_pending) reply_pending <= 1'b0;
      if (any_grant) begin
        owner <= grant_idx;
        if (req_reply[grant_idx]) begin
          reply_pending <= 1'b1;
          reply_owner   <= grant_idx;
        end
      end
    end
  end

  tx_framer #(
    .NSHIFT         (NSHIFT),
    .PAYLOAD_CYCLES (PAYLOAD_CYCLES),
    .TX_CMD_BITS    (TX_CMD_BITS)
  ) u_framer (
    .clk        (clk),
    .reset      (reset),
    .start      (any_grant),
    .cmd        (grant_cmd),
    .data       (owner_data),
    .idle       (framer_idle),
    .payload    (framer_payload),
    .last       (framer_last),
    .tx_pins    (tx_pins),
    .tx_active  (tx_active),
    .tx_counter (tx_counter)
  );

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: directed scenarios plus random traffic against a frame-position model.
module tb_tx_arbiter;

  localparam int NSHIFT = 2;
  localparam int TXB    = 2;
  localparam int PC     = 8;
  localparam int CC     = TXB / NSHIFT;
  localparam int FRAME  = 1 + CC + PC;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [1:0]           req_valid, req_reply;
  logic [2*TXB-1:0]     req_cmd;
  logic [2*NSHIFT-1:0]  req_data;
  logic                 reserve, rx_done;
  logic [1:0]           started, data_next, done, reply_done;
  logic [NSHIFT-1:0]    tx_pins;
  logic                 tx_active;
  logic [3:0]           tx_counter;

  always #5 clk = ~clk;

  tx_arbiter #(
    .NSHIFT         (NSHIFT),
    .PAYLOAD_CYCLES (PC),
    .TX_CMD_BITS    (TXB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_cmd    (req_cmd),
    .req_reply  (req_reply),
    .req_data   (req_data),
    .reserve    (reserve),
    .started    (started),
    .data_next  (data_next),
    .done       (done),
    .reply_done (reply_done),
    .rx_done    (rx_done),
    .tx_pins    (tx_pins),
    .tx_active  (tx_active),
    .tx_counter (tx_counter)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model: m_pos 0 = idle, 1 = start, 2..1+CC = command, 2+CC..FRAME = payload
  int         m_pos = 0;
  int         m_owner = 0;
  logic [TXB-1:0] m_cmd = '0;
  logic       m_pending = 1'b0;
  int         m_rowner = 0;

  int st_cyc[2] = '{-1, -1};
  int dn_cyc[2] = '{-1, -1};
  int rd_cyc[2] = '{-1, -1};
  logic [NSHIFT-1:0] pin_hist [0:4095];
  logic              act_hist [0:4095];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    logic [1:0] elig, e_st, e_dn, e_done, e_rd;
    logic [NSHIFT-1:0] e_pins;
    logic [TXB-1:0] tmp;
    logic [3:0] e_cnt;
    #1;
    elig[0] = req_valid[0] && !(req_reply[0] && m_pending);
    elig[1] = req_valid[1] && !(req_reply[1] && m_pending) && !reserve;
    e_st = 2'b00;
    if (m_pos == 0 && !reset) e_st = elig[0] ? 2'b01 : (elig[1] ? 2'b10 : 2'b00);
    e_pins = '0; e_dn = '0; e_done = '0; e_cnt = '0; e_rd = '0;
    if (m_pos == 1) e_pins = '1;
    else if (m_pos >= 2 && m_pos < 2 + CC) begin
      tmp    = m_cmd >> (TXB - NSHIFT * (m_pos - 1));
      e_pins = tmp[NSHIFT-1:0];
    end else if (m_pos >= 2 + CC) begin
      e_pins         = req_data[m_owner*NSHIFT +: NSHIFT];
      e_dn[m_owner]  = 1'b1;
      e_cnt          = 4'(m_pos - 2 - CC);
      if (m_pos == FRAME) e_done[m_owner] = 1'b1;
    end
    if (rx_done && m_pending && !reset) e_rd[m_rowner] = 1'b1;

    chk("started",    32'(started),    32'(e_st));
    chk("data_next",  32'(data_next),  32'(e_dn));
    chk("done",       32'(done),       32'(e_done));
    chk("reply_done", 32'(reply_done), 32'(e_rd));
    chk("tx_pins",    32'(tx_pins),    32'(e_pins));
    chk("tx_active",  32'(tx_active),  32'(m_pos != 0));
    chk("tx_counter", 32'(tx_counter), 32'(e_cnt));

    pin_hist[cyc] = tx_pins;
    act_hist[cyc] = tx_active;
    for (int i = 0; i < 2; i++) begin
      if (started[i])    st_cyc[i] = cyc;
      if (done[i])       dn_cyc[i] = cyc;
      if (reply_done[i]) rd_cyc[i] = cyc;
    end

    if (reset) begin
      m_pos = 0;
      m_pending = 1'b0;
    end else begin
      if (rx_done && m_pending) m_pending = 1'b0;
      if (m_pos == 0) begin
        if (e_st != 2'b00) begin
          m_owner = e_st[1] ? 1 : 0;
          m_cmd   = req_cmd[m_owner*TXB +: TXB];
          if (req_reply[m_owner]) begin
            m_pending = 1'b1;
            m_rowner  = m_owner;
          end
          m_pos = 1;
        end
      end else begin
        m_pos = (m_pos == FRAME) ? 0 : m_pos + 1;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int t0, trx, prev, prev_d0;
    reset = 1'b1; req_valid = '0; req_reply = '0; req_cmd = '0; req_data = '0;
    reserve = 1'b0; rx_done = 1'b0;
    @(negedge clk);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("reset_outputs", 32'({started, data_next, done, reply_done, tx_pins, tx_active, tx_counter}), 32'd0);

    // single prefetch request
    req_cmd = 4'b0100; req_data = 4'b1001; req_valid = 2'b10;
    t0 = cyc; tick();
    req_valid = 2'b00;
    repeat (11) tick();
    chk("pf_started", 32'(st_cyc[1]), 32'(t0));
    chk("pf_done",    32'(dn_cyc[1]), 32'(t0 + 10));
    chk("pf_pins_t1", 32'(pin_hist[t0+1]), 32'd3);
    chk("pf_pins_t2", 32'(pin_hist[t0+2]), 32'd1);
    chk("pf_act_t10", 32'(act_hist[t0+10]), 32'd1);
    chk("pf_act_t11", 32'(act_hist[t0+11]), 32'd0);

    // simultaneous requests
    req_cmd = 4'b1110; req_valid = 2'b11;
    t0 = cyc; prev = st_cyc[1]; tick();
    req_valid = 2'b10;
    for (int i = 0; i < 30 && st_cyc[1] == prev; i++) tick();
    req_valid = 2'b00;
    repeat (11) tick();
    chk("sim_first",  32'(st_cyc[0]), 32'(t0));
    chk("sim_second", 32'(st_cyc[1]), 32'(dn_cyc[0] + 1));

    // reservation holds off the prefetch requester
    reserve = 1'b1; req_valid = 2'b10; prev = st_cyc[1];
    repeat (20) tick();
    chk("rsv_block", 32'(st_cyc[1]), 32'(prev));
    reserve = 1'b0;
    t0 = cyc; tick();
    req_valid = 2'b00;
    repeat (11) tick();
    chk("rsv_grant", 32'(st_cyc[1]), 32'(t0));

    // reply tracking blocks a second reply-wanting requester
    req_valid = 2'b01; req_reply = 2'b01; prev_d0 = dn_cyc[0];
    t0 = cyc; tick();
    req_valid = 2'b10; req_reply = 2'b10;
    for (int i = 0; i < 20 && dn_cyc[0] == prev_d0; i++) tick();
    repeat (4) tick();
    rx_done = 1'b1; trx = cyc; tick();
    rx_done = 1'b0; tick();
    req_valid = 2'b00; req_reply = 2'b00;
    repeat (11) tick();
    chk("rep_sched_start", 32'(st_cyc[0]), 32'(t0));
    chk("rep_rx_at_done5", 32'(trx), 32'(dn_cyc[0] + 5));
    chk("rep_done",        32'(rd_cyc[0]), 32'(trx));
    chk("rep_grant",       32'(st_cyc[1]), 32'(trx + 1));
    rx_done = 1'b1; tick();
    rx_done = 1'b0; tick();

    // reset in payload cycle 3 with a reply outstanding
    req_valid = 2'b01; req_reply = 2'b01; prev_d0 = dn_cyc[0]; prev = rd_cyc[0];
    tick();
    req_valid = 2'b00; req_reply = 2'b00;
    repeat (5) tick();
    chk("rst_mid_cnt", 32'(tx_counter), 32'd3);
    reset = 1'b1; tick();
    reset = 1'b0; trx = cyc; tick();
    chk("rst_act",    32'(act_hist[trx]), 32'd0);
    chk("rst_pins",   32'(pin_hist[trx]), 32'd0);
    chk("rst_nodone", 32'(dn_cyc[0]), 32'(prev_d0));
    req_valid = 2'b01; req_reply = 2'b01;
    t0 = cyc; tick();
    req_valid = 2'b00; req_reply = 2'b00;
    repeat (11) tick();
    chk("rst_regrant", 32'(st_cyc[0]), 32'(t0));
    chk("rst_noreply", 32'(rd_cyc[0]), 32'(prev));

    // random traffic
    repeat (600) begin
      reset     = ($urandom_range(0, 59) == 0);
      req_valid = 2'($urandom);
      req_reply = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      reserve   = ($urandom_range(0, 3) == 0);
      rx_done   = ($urandom_range(0, 6) == 0);
      req_cmd   = 4'($urandom);
      req_data  = 4'($urandom);
      tick();
    end
    reset = 1'b0; req_valid = '0; req_reply = '0; reserve = 1'b0; rx_done = 1'b0;
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
